// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared constants for the shared-divider scheduler: FSM state
//            encodings and default datapath geometry.
// Contents : ST_IDLE / ST_ITER / ST_FIN  - 2-bit state encodings
//            DEFAULT_WIDTH               - default operand/result width
//            DEFAULT_NREQ                - default requester count
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ITER = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_NREQ  = 4;

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module   : div_core
// Purpose  : Restoring shift-subtract divider datapath, one quotient bit per
//            step, MSB first.
// Ports    : clk, rst_n - clock, async active-low reset
//            ld         - load dividend/divisor, clear partial remainder
//            step       - perform one iteration
//            a, b       - dividend / divisor loaded on ld
//            q, r       - quotient / remainder as they will stand after the
//                         iteration performed in this cycle (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  // r_acc starts as the dividend; each step shifts its MSB into the remainder
  // and shifts the new quotient bit into its LSB, so after WIDTH steps it
  // holds the quotient.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_acc_nx;

  always_comb begin
    w_rem_sh = {r_rem, r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*b and a non-negative difference never sets the top bit:
    // the top bit of the trial subtraction is exactly the borrow.
    w_ge     = ~w_diff[WIDTH];
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_acc_nx = {r_acc[WIDTH-2:0], w_ge};
    q        = w_acc_nx;
    r        = w_rem_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_b   <= '0;
    end else if (ld) begin
      r_acc <= a;
      r_rem <= '0;
      r_b   <= b;
    end else if (step) begin
      r_acc <= w_acc_nx;
      r_rem <= w_rem_nx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_sched
// Purpose  : Round-robin scheduler in front of a single shared restoring
//            divider. Grants one requester at a time, runs WIDTH iterations
//            and returns quotient, remainder, requester id and a divide-by-
//            zero flag with a one-cycle done pulse.
// Ports    : clk, rst_n      - clock, async active-low reset
//            req[NREQ]       - request levels
//            a_in, b_in      - packed dividends/divisors, id i at [i*WIDTH+:WIDTH]
//            gnt[NREQ]       - one-hot combinational grant (IDLE only)
//            busy            - high outside IDLE
//            done            - one-cycle result-valid pulse
//            done_id, q, r, dz - result, held until the next done
// Config   : DIV_ZERO_FAST_EN - when defined, a zero divisor skips the
//            iterations and the result is returned the cycle after grant.
// Revision : 1.0 - initial release
// ============================================================================
module div_sched
  import div_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        r,
  output logic                    dz
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CNTW-1:0]  r_cnt;
  logic             r_bz;

  logic             w_any_hi, w_any_lo, w_any;
  logic [IDW-1:0]   w_id_hi, w_id_lo, w_gnt_id;
  logic [WIDTH-1:0] w_a_sel, w_b_sel;
  logic             w_ld, w_step;
  logic [WIDTH-1:0] w_core_q, w_core_r;

  // Round-robin arbitration: the lowest requester above ptr wins; if none,
  // the lowest requester at or below ptr (wrap-around).
  always_comb begin
    w_any_hi = 1'b0;
    w_any_lo = 1'b0;
    w_id_hi  = '0;
    w_id_lo  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j]) begin
        if (IDW'(j) > r_ptr) begin
          if (!w_any_hi) begin
            w_any_hi = 1'b1;
            w_id_hi  = IDW'(j);
          end
        end else if (!w_any_lo) begin
          w_any_lo = 1'b1;
          w_id_lo  = IDW'(j);
        end
      end
    end
    w_any    = w_any_hi | w_any_lo;
    w_gnt_id = w_any_hi ? w_id_hi : w_id_lo;
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_gnt_id) begin
        w_a_sel = a_in[j*WIDTH +: WIDTH];
        w_b_sel = b_in[j*WIDTH +: WIDTH];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM: next state
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_nx = (w_b_sel == '0) ? ST_FIN : ST_ITER;
`else
          w_state_nx = ST_ITER;
`endif
        end
      end
      ST_ITER: if (r_cnt == CNTW'(1)) w_state_nx = ST_FIN;
      ST_FIN:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    gnt  = '0;
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_FIN);
    if (r_state == ST_IDLE && w_any) begin
      for (int j = 0; j < NREQ; j++) gnt[j] = (IDW'(j) == w_gnt_id);
    end
  end

  assign w_ld   = (r_state == ST_IDLE) && w_any;
  assign w_step = (r_state == ST_ITER);

  // Pointer, counter, latched id/zero flag and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_cnt   <= '0;
      r_bz    <= 1'b0;
      done_id <= '0;
      q       <= '0;
      r       <= '0;
      dz      <= 1'b0;
    end else begin
      if (w_ld) begin
        r_ptr <= w_gnt_id;
        r_id  <= w_gnt_id;
        r_bz  <= (w_b_sel == '0);
        r_cnt <= CNTW'(WIDTH);
      end else if (w_step) begin
        r_cnt <= r_cnt - CNTW'(1);
      end

      // Results are captured on the edge that enters FIN; the core's outputs
      // already reflect the final iteration happening on that same edge.
      if (r_state == ST_ITER && w_state_nx == ST_FIN) begin
        q       <= w_core_q;
        r       <= w_core_r;
        dz      <= r_bz;
        done_id <= r_id;
      end
`ifdef DIV_ZERO_FAST_EN
      else if (r_state == ST_IDLE && w_state_nx == ST_FIN) begin
        q       <= '1;
        r       <= w_a_sel;
        dz      <= 1'b1;
        done_id <= w_gnt_id;
      end
`endif
    end
  end

  div_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (w_ld),
    .step  (w_step),
    .a     (w_a_sel),
    .b     (w_b_sel),
    .q     (w_core_q),
    .r     (w_core_r)
  );

endmodule
`default_nettype wire

// File: doc/div_sched.md
# div_sched

Shared-divider scheduler for the unsigned shift-subtract divide datapath. It accepts divide requests from up to NREQ requesters, grants one at a time in round-robin order, and runs a WIDTH-iteration restoring division on the granted operands. It returns quotient, remainder and the requester id with a one-cycle done pulse. It sits between several client FSMs and the single divider datapath, so the datapath is shared instead of duplicated per client.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 6, operand/result width in bits
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  NREQ  per-requester request level
- A_IN  in  NREQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
- B_IN  in  NREQ*WIDTH  divisors, same packing
- GNT  out  NREQ  one-hot grant; combinational, asserted only in IDLE
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle result-valid pulse
- DONE_ID  out  $clog2(NREQ)  id of the requester whose result is on Q/R
- Q  out  WIDTH  quotient
- R  out  WIDTH  remainder
- DZ  out  1  divide-by-zero flag, valid with DONE, held like Q/R

## Operation
- States: IDLE, ITER, FIN.
- IDLE:
  - If any REQ bit is high, GNT selects the first requester searching upward from ptr+1 with wrap.
  - At the clock edge, the block latches A/B/id of the granted requester, sets ptr to that id, sets count to WIDTH, clears the remainder, and moves to ITER.
- Requester handshake:
  - A requester holds REQ and its operands until it sees its GNT bit.
  - Operands are sampled on the edge that ends the GNT cycle.
  - Dropping REQ before GNT is legal and withdraws the request.
- ITER, one quotient bit per cycle, MSB first:
  - rem = {rem[WIDTH-1:0], a_msb}; a shifts left.
  - If rem >= B: rem -= B and the quotient bit is 1; otherwise the quotient bit is 0.
  - rem is WIDTH+1 bits wide; the compare and subtract are WIDTH+1 bits.
  - count decrements each cycle; ITER moves to FIN when count reaches 1.
- FIN:
  - DONE=1; Q, R, DONE_ID and DZ update on entry.
  - Next state is IDLE. No new grant is issued in FIN.
- Q/R/DONE_ID/DZ hold their last value until the next FIN.
- B=0 produces Q = all ones, R = A, DZ = 1.
- REQ changes while BUSY are ignored; no grant is issued until IDLE.
- ptr updates only on a grant.

## Timing
- Reset values: state IDLE, ptr = NREQ-1 (so id 0 wins first), GNT=0, BUSY=0, DONE=0, DONE_ID=0, Q=0, R=0, DZ=0.
- Cycle numbering: grant in cycle k, ITER in cycles k+1..k+WIDTH, DONE in cycle k+WIDTH+1.
- Earliest next grant is cycle k+WIDTH+2, so throughput is one divide per WIDTH+2 cycles.
- Reset mid-operation aborts at once: no DONE, outputs return to reset values.
- GNT depends combinationally on REQ and state only; DONE, Q and R are registered.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - If the latched B is 0 at grant, the block skips ITER and goes IDLE → FIN.
  - DONE occurs in cycle k+1 with Q = all ones, R = A, DZ = 1.
- DIV_ZERO_FAST_EN not defined:
  - B=0 runs all WIDTH iterations; the restoring algorithm yields Q = all ones and R = A naturally.
  - DZ = 1 at DONE in cycle k+WIDTH+1.

## Structure
- Package div_pkg holds:
  - state encoding localparams ST_IDLE=2'b00, ST_ITER=2'b01, ST_FIN=2'b10;
  - the default WIDTH and NREQ constants.
- Sub-module div_core holds the rem/a/q registers and one iteration step, with ports ld, step, a, b, q, r.
- div_sched keeps the FSM, the counter, the round-robin pointer/grant logic and the operand mux.

## Test plan
- REQ=4'b0001, A=45, B=6 → GNT=0001 in cycle 0; DONE in cycle 7 with Q=7, R=3, DONE_ID=0, DZ=0.
- REQ=4'b1111 held continuously → grants in order 0,1,2,3,0, spaced 8 cycles apart; DONE_ID follows the same order.
- A=13, B=0 → Q=63, R=13, DZ=1; DONE at cycle 1 with DIV_ZERO_FAST_EN defined, at cycle 7 without it.
- Edge operands: A=5, B=9 → Q=0, R=5; A=63, B=1 → Q=63, R=0; A=0, B=7 → Q=0, R=0.
- REQ[2] raised during ITER of id 0 → no GNT while BUSY; GNT=0100 in the first IDLE cycle after DONE.
- RST_N pulsed low during cycle 3 of ITER → no DONE; Q=R=0; the next REQ=4'b1010 grants id 1 first.
